// File: rtl/io_port_pkg.sv
// Shared constants and helpers for the multi-channel CPU input port.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package io_port_pkg;

  localparam int IO_BUS_W  = 32;
  localparam int IO_MAX_CH = 16;

  // Ceiling log2. Used for pointer and select widths; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/in_port_channel.sv
// One input channel: strobe synchroniser, rising-edge detect, FWFT FIFO, sticky overflow.
// Latency: strobe first sampled high at edge k -> entry written and visible after edge k+2.
// Backpressure: none upstream; a push into a full FIFO with no pop is dropped and flagged.
module in_port_channel
  import io_port_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] head,
  output logic              not_empty,
  output logic              full,
  output logic              overflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              s1, s2, s3;
  logic              push;
  logic              do_push;
  logic              do_pop;
  logic              drop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];

  // A push is the synchronised strobe's rising edge, so a held strobe pushes once.
  assign push      = s2 & ~s3;
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  // A pop frees a slot on the same edge, so a full FIFO can still accept the push.
  assign do_pop    = pop & not_empty;
  assign do_push   = push & (~full | do_pop);
  assign drop      = push & full & ~do_pop;
  assign head      = mem[rd_ptr];

  // Two-flop synchroniser for the asynchronous strobe plus one history flop for edge detect.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is what defines which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // Sticky overflow; a new drop on the same edge as a status clear keeps the bit set.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_in_port.sv
// Multi-channel CPU input port: per-channel capture FIFOs, read mux and status word.
// Latency: bus_out is combinational from rd_en/stat_rd/ch_sel; pop and overflow clear at the next edge.
// Backpressure: reads of empty or nonexistent channels return 0 and change nothing.
module multi_in_port
  import io_port_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int BUS_W  = IO_BUS_W
) (
  input  logic                                        clock,
  input  logic                                        clear,
  input  logic [NUM_CH*DATA_W-1:0]                    in_data,
  input  logic [NUM_CH-1:0]                           in_strobe,
  input  logic [((NUM_CH > 1) ? clog2(NUM_CH) : 1)-1:0] ch_sel,
  input  logic                                        rd_en,
  input  logic                                        stat_rd,
  output logic [BUS_W-1:0]                            bus_out,
  output logic [NUM_CH-1:0]                           not_empty,
  output logic [NUM_CH-1:0]                           full,
  output logic [NUM_CH-1:0]                           overflow
);

  localparam int SEL_W        = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int STAT_NE_LSB  = 0;
  localparam int STAT_OVF_LSB = NUM_CH;

  logic [NUM_CH-1:0][DATA_W-1:0] heads;
  logic [NUM_CH-1:0]             pop;
  logic                          sel_ok;
  logic                          ch_rd;

  // Status read wins over a channel read, so a combined request never pops.
  assign sel_ok = (32'(ch_sel) < NUM_CH);
  assign ch_rd  = rd_en & ~stat_rd & sel_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign pop[i] = ch_rd & (ch_sel == SEL_W'(i));

    in_port_channel #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ch (
      .clock     (clock),
      .clear     (clear),
      .strobe    (in_strobe[i]),
      .data      (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .ovf_clr   (stat_rd),
      .head      (heads[i]),
      .not_empty (not_empty[i]),
      .full      (full[i]),
      .overflow  (overflow[i])
    );
  end

  // Read mux: status word, selected head, or zero so the port can be OR-ed onto the bus.
  always_comb begin
    bus_out = '0;
    if (stat_rd) begin
      bus_out[STAT_NE_LSB  +: NUM_CH] = not_empty;
      bus_out[STAT_OVF_LSB +: NUM_CH] = overflow;
    end else if (ch_rd && not_empty[ch_sel]) begin
      bus_out[DATA_W-1:0] = heads[ch_sel];
    end
  end

endmodule

// File: tb/tb_multi_in_port.sv
// Testbench for multi_in_port: directed scenarios then random traffic against a queue model.
// Latency: model schedules each push two edges after the strobe is first sampled high.
// Backpressure: model drops pushes into a full queue unless the same edge pops it.
module tb_multi_in_port;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DP  = 4;
  localparam int BW  = 32;

  logic              clock;
  logic              clear;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_strobe;
  logic [1:0]        ch_sel;
  logic              rd_en;
  logic              stat_rd;
  logic [BW-1:0]     bus_out;
  logic [NCH-1:0]    not_empty;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    overflow;

  multi_in_port #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DP), .BUS_W(BW)) dut (
    .clock     (clock),
    .clear     (clear),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .ch_sel    (ch_sel),
    .rd_en     (rd_en),
    .stat_rd   (stat_rd),
    .bus_out   (bus_out),
    .not_empty (not_empty),
    .full      (full),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel, sticky overflow bits, scheduled pushes.
  logic [DW-1:0] mq [NCH][$];
  logic [NCH-1:0] movf;
  int             sched_edge [NCH];
  logic [DW-1:0]  sched_dat  [NCH];
  int             scnt       [NCH];
  int             edge_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      sched_edge[c] = -1;
      scnt[c] = 0;
    end
    movf = '0;
    in_strobe = '0;
  endtask

  function automatic logic [31:0] exp_bus();
    logic [31:0] r;
    int c;
    r = '0;
    c = int'(ch_sel);
    if (stat_rd) begin
      for (int i = 0; i < NCH; i++) begin
        r[i]       = (mq[i].size() != 0);
        r[NCH + i] = movf[i];
      end
    end else if (rd_en && c < NCH && mq[c].size() != 0) begin
      r = 32'(mq[c][0]);
    end
    return r;
  endfunction

  task automatic check_all();
    logic [NCH-1:0] ene, efu;
    for (int c = 0; c < NCH; c++) begin
      ene[c] = (mq[c].size() != 0);
      efu[c] = (mq[c].size() == DP);
    end
    chk("not_empty", 32'(not_empty), 32'(ene));
    chk("full", 32'(full), 32'(efu));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("bus_out", bus_out, exp_bus());
  endtask

  // Apply one clock edge to the model using the inputs held across that edge.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit p;
      p = rd_en && !stat_rd && int'(ch_sel) == c && mq[c].size() != 0;
      if (stat_rd) movf[c] = 1'b0;
      if (p) void'(mq[c].pop_front());
      if (sched_edge[c] == edge_n) begin
        if (mq[c].size() == DP) movf[c] = 1'b1;
        else mq[c].push_back(sched_dat[c]);
        sched_edge[c] = -1;
      end
    end
  endtask

  task automatic strobe_tick();
    for (int c = 0; c < NCH; c++) begin
      if (scnt[c] > 0) begin
        scnt[c]--;
        if (scnt[c] == 4) in_strobe[c] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clock);
    edge_n++;
    model_edge();
    #1;
    strobe_tick();
  endtask

  // Strobe held for three sampled edges, then low long enough to re-arm the edge detect.
  task automatic start_strobe(input int c, input logic [DW-1:0] d);
    in_data[c*DW +: DW] = d;
    in_strobe[c] = 1'b1;
    sched_edge[c] = edge_n + 3;
    sched_dat[c] = d;
    scnt[c] = 7;
  endtask

  task automatic push(input int c, input logic [DW-1:0] d);
    start_strobe(c, d);
    repeat (7) cycle();
  endtask

  task automatic read(input int c, input logic [7:0] exp);
    rd_en = 1'b1;
    ch_sel = 2'(c);
    #1;
    chk("read", bus_out, 32'(exp));
    cycle();
    rd_en = 1'b0;
  endtask

  initial begin
    clear = 1'b0;
    in_data = '0;
    in_strobe = '0;
    ch_sel = '0;
    rd_en = 1'b0;
    stat_rd = 1'b0;
    edge_n = 0;
    model_reset();

    // Reset then idle
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ne", 32'(not_empty), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_bus", bus_out, 32'h0);
    @(negedge clock);
    clear = 1'b1;
    rd_en = 1'b1;
    ch_sel = 2'd0;
    #1;
    chk("idle_rd_bus", bus_out, 32'h0);
    cycle();
    rd_en = 1'b0;

    // Single capture on ch2 with exact visibility timing
    start_strobe(2, 8'hA5);
    cycle();
    cycle();
    chk("cap_ne_early", 32'(not_empty[2]), 32'h0);
    cycle();
    chk("cap_ne_k2", 32'(not_empty[2]), 32'h1);
    repeat (4) cycle();
    read(2, 8'hA5);
    chk("cap_ne_after", 32'(not_empty[2]), 32'h0);

    // Fill and overflow on ch0
    for (int i = 1; i <= 5; i++) begin
      push(0, 8'(i));
      if (i == 4) chk("fill_full", 32'(full[0]), 32'h1);
      if (i == 4) chk("fill_noovf", 32'(overflow[0]), 32'h0);
    end
    chk("fill_ovf", 32'(overflow[0]), 32'h1);
    for (int i = 1; i <= 4; i++) read(0, 8'(i));
    chk("fill_drained", 32'(not_empty[0]), 32'h0);

    // Status reads
    stat_rd = 1'b1;
    #1;
    chk("stat_ch0ovf", bus_out, 32'h10);
    cycle();
    stat_rd = 1'b0;
    chk("stat_clr0", 32'(overflow), 32'h0);
    push(1, 8'h11);
    for (int i = 1; i <= 5; i++) push(3, 8'(8'h30 + i));
    for (int i = 1; i <= 4; i++) read(3, 8'(8'h30 + i));
    stat_rd = 1'b1;
    #1;
    chk("stat_word", bus_out, 32'h82);
    cycle();
    stat_rd = 1'b0;
    chk("stat_clr3", 32'(overflow[3]), 32'h0);
    stat_rd = 1'b1;
    rd_en = 1'b1;
    ch_sel = 2'd1;
    #1;
    chk("stat_prio_bus", bus_out, 32'h02);
    cycle();
    stat_rd = 1'b0;
    rd_en = 1'b0;
    chk("stat_prio_nopop", 32'(not_empty[1]), 32'h1);

    // Full ch1 with push and pop on the same edge
    for (int i = 2; i <= 4; i++) push(1, 8'(8'h10 + i));
    chk("pp_full_before", 32'(full[1]), 32'h1);
    start_strobe(1, 8'h15);
    cycle();
    cycle();
    rd_en = 1'b1;
    ch_sel = 2'd1;
    #1;
    chk("pp_head", bus_out, 32'h11);
    cycle();
    rd_en = 1'b0;
    chk("pp_full_after", 32'(full[1]), 32'h1);
    chk("pp_noovf", 32'(overflow[1]), 32'h0);
    repeat (4) cycle();
    for (int i = 2; i <= 5; i++) read(1, 8'(8'h10 + i));

    // Asynchronous reset while ch0 holds three entries
    for (int i = 1; i <= 3; i++) push(0, 8'(8'h40 + i));
    rd_en = 1'b1;
    ch_sel = 2'd0;
    #1;
    chk("ar_head", bus_out, 32'h41);
    #1;
    clear = 1'b0;
    #1;
    chk("ar_ne", 32'(not_empty), 32'h0);
    chk("ar_full", 32'(full), 32'h0);
    chk("ar_bus", bus_out, 32'h0);
    model_reset();
    @(negedge clock);
    clear = 1'b1;
    cycle();
    chk("ar_stale", bus_out, 32'h0);
    rd_en = 1'b0;

    // Random traffic on all channels
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (scnt[c] == 0 && $urandom_range(0, 2) == 0) start_strobe(c, 8'($urandom));
      end
      rd_en = ($urandom_range(0, 3) == 0);
      stat_rd = ($urandom_range(0, 9) == 0);
      ch_sel = 2'($urandom_range(0, NCH - 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
